// File: rtl/stage_mem_access_if.sv
// -----------------------------------------------------------------------------
// stage_mem_access_if
// Data-memory request/response bundle between the memory-access stage and the
// data memory.
//
// Signals:
//   Address          word-aligned request address           (stage -> memory)
//   MemWrite         store request                          (stage -> memory)
//   Write_data       store data                             (stage -> memory)
//   Write_strb       store byte enables                     (stage -> memory)
//   MemRead          load request                           (stage -> memory)
//   Mem_Req_Ready    memory accepts the current request     (memory -> stage)
//   Read_data        load response data                     (memory -> stage)
//   Read_data_Valid  load response valid                    (memory -> stage)
//   Read_data_Ready  stage accepts the load response        (stage -> memory)
//
// Modports: master = pipeline stage, slave = data memory.
// -----------------------------------------------------------------------------
interface stage_mem_access_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/stage_mem_access.sv
// -----------------------------------------------------------------------------
// stage_mem_access
// Memory-access / write-back stage of the multi-cycle-handshake RV32 pipeline.
// Takes one instruction at a time from the execute stage, performs its load or
// store on the data-memory channel (if any), extends load data, and retires the
// instruction through the register-file write port. While an access is in
// flight Feedback_Mem_Acc freezes the upstream stages.
//
// Parameters:
//   STALL_CNT_W   width of the stall-cycle counter (wraps).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   PC_I, Done_I       incoming instruction PC and valid
//   MCR                {MemW, MemR, Write_strb[3:0]}
//   WDR                lane-shifted store data
//   ASR                ALU result / effective address
//   RAR_I              destination register (0 = no write)
//   F3R                Funct3 (load width and signedness)
//   mem                data-memory request/response bundle (master side)
//   Feedback_Mem_Acc   stall request to upstream stages
//   Done_O, PC_O       retirement strobe and PC of the retiring instruction
//   RF_wen/waddr/wdata register-file write port
//   MDR                extended load data (forwarding source for decode)
//   Stall_Cnt          number of cycles spent with Feedback_Mem_Acc high
// -----------------------------------------------------------------------------
module stage_mem_access #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            PC_I,
  input  logic                   Done_I,
  input  logic [5:0]             MCR,
  input  logic [31:0]            WDR,
  input  logic [31:0]            ASR,
  input  logic [4:0]             RAR_I,
  input  logic [2:0]             F3R,
  stage_mem_access_if.master     mem,
  output logic                   Feedback_Mem_Acc,
  output logic                   Done_O,
  output logic [31:0]            PC_O,
  output logic                   RF_wen,
  output logic [4:0]             RF_waddr,
  output logic [31:0]            RF_wdata,
  output logic [31:0]            MDR,
  output logic [STALL_CNT_W-1:0] Stall_Cnt
);

  typedef enum logic [4:0] {
    s_IDLE = 5'b00001,
    s_LD   = 5'b00010,
    s_RDW  = 5'b00100,
    s_ST   = 5'b01000,
    s_WB   = 5'b10000
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        rsp_fire;
  logic        in_ld;
  logic        in_st;
  logic        in_rdw;
  logic        in_wb;
  logic        req_active;

  // Only MemR and the strobes are needed after acceptance; MemW has already
  // chosen the next state by then.
  logic [4:0]  MCR_r;
  logic [4:0]  RAR_r;
  logic [31:0] PC_r;
  logic [31:0] WDR_r;
  logic [31:0] ASR_r;
  logic [2:0]  F3R_r;
  logic [31:0] load_ext;

  // Selects the addressed byte/halfword of the response word and extends it.
  // Unsupported Funct3 encodings fall back to a full-word load.
  function automatic logic [31:0] extend_load(
    input logic [31:0] data,
    input logic [1:0]  offset,
    input logic [2:0]  f3
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    case (offset)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = offset[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  result = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  result = {24'h000000, byte_sel};
      3'b001:  result = {{16{half_sel[15]}}, half_sel};
      3'b101:  result = {16'h0000, half_sel};
      default: result = data;
    endcase
    return result;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Idle and write-back are both able to take a new instruction, which is what
  // lets ALU-only streams retire on consecutive cycles. A store wins over a
  // load when both MemW and MemR are set.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      s_IDLE, s_WB: begin
        if (Done_I) begin
          accept = 1'b1;
          if (MCR[5]) begin
            state_next = s_ST;
          end else if (MCR[4]) begin
            state_next = s_LD;
          end else begin
            state_next = s_WB;
          end
        end else begin
          state_next = s_IDLE;
        end
      end
      s_ST: begin
        if (mem.Mem_Req_Ready) begin
          state_next = s_WB;
        end
      end
      s_LD: begin
        if (mem.Mem_Req_Ready) begin
          state_next = s_RDW;
        end
      end
      s_RDW: begin
        if (mem.Read_data_Valid) begin
          rsp_fire   = 1'b1;
          state_next = s_WB;
        end
      end
      default: begin
        state_next = s_IDLE;
      end
    endcase
  end

  assign in_ld      = (state == s_LD);
  assign in_st      = (state == s_ST);
  assign in_rdw     = (state == s_RDW);
  assign in_wb      = (state == s_WB);
  assign req_active = in_ld | in_st;

  assign mem.MemRead         = in_ld;
  assign mem.MemWrite        = in_st;
  assign mem.Address         = req_active ? {ASR_r[31:2], 2'b00} : 32'h0000_0000;
  assign mem.Write_data      = req_active ? WDR_r : 32'h0000_0000;
  assign mem.Write_strb      = in_st ? MCR_r[3:0] : 4'h0;
  assign mem.Read_data_Ready = in_rdw;

  assign Feedback_Mem_Acc = req_active | in_rdw;
  assign Done_O           = in_wb;
  assign PC_O             = PC_r;
  assign RF_wen           = in_wb && (RAR_r != 5'd0);
  assign RF_waddr         = RAR_r;
  assign RF_wdata         = MCR_r[4] ? MDR : ASR_r;

  assign load_ext = extend_load(mem.Read_data, ASR_r[1:0], F3R_r);

  // Control fields are reset so a reset during an access can never produce a
  // stray register write.
  always_ff @(posedge clk) begin
    if (rst) begin
      MCR_r <= 5'd0;
      RAR_r <= 5'd0;
    end else if (accept) begin
      MCR_r <= MCR[4:0];
      RAR_r <= RAR_I;
    end
  end

  // Datapath registers carry no reset; they are only observed after a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      PC_r  <= PC_I;
      WDR_r <= WDR;
      ASR_r <= ASR;
      F3R_r <= F3R;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      MDR <= load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Cnt <= '0;
    end else if (Feedback_Mem_Acc) begin
      Stall_Cnt <= Stall_Cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
